run_control: RTL and testbench

//  Front-panel run/stop/step controller directly upstream of clock_generator.

---
 rtl/run_control.sv | 246 ++++++++++++++++++++++++
 tb/tb_run_control.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/run_control.sv
// ---------------------------------------------------------------------------
// run_control
//
// Front-panel run/stop/step controller that sits directly upstream of
// clock_generator. The RUN, STOP and STEP buttons are synchronised and
// debounced, then merged with the microcode HALT request. The result is a
// registered clock enable that gates processor cycles. The enable is only
// dropped on a processor-cycle boundary (cycle_end), so a processor cycle is
// never cut short. The one exception is reset, which drops it immediately.
//
// Optional feature (compile-time macro RUNCTL_CYCLE_COUNT_EN):
//   When defined, adds a 16-bit wrapping count of processor cycles that
//   completed while the clock enable was asserted.
//
// Parameters
//   DB_W          debounce counter width
//   DEBOUNCE_LEN  consecutive stable cycles needed to accept a button level
//                 change (1 .. 2**DB_W-1)
//
// Ports
//   rawclk       in   master clock (the only clock)
//   reset        in   asynchronous reset, active low
//   fp_run_n     in   RUN button, active low, asynchronous, bouncy
//   fp_stop_n    in   STOP button, active low, asynchronous, bouncy
//   fp_step_n    in   STEP button, active low, asynchronous, bouncy
//   halt_n       in   microcode HALT request, active low, synchronous
//   cycle_end    in   1-cycle pulse on the last rawclk of a processor cycle
//   clken        out  registered clock enable to clock_generator
//   running      out  RUN lamp (state is RUNNING)
//   stopped      out  STOP lamp (state is STOPPED)
//   step_done    out  1-cycle pulse when a single step completes
//   cycle_count  out  [15:0] completed enabled cycles (RUNCTL_CYCLE_COUNT_EN)
// ---------------------------------------------------------------------------
module run_control #(
    parameter int DB_W         = 4,
    parameter int DEBOUNCE_LEN = 8
) (
    input  logic        rawclk,
    input  logic        reset,
    input  logic        fp_run_n,
    input  logic        fp_stop_n,
    input  logic        fp_step_n,
    input  logic        halt_n,
    input  logic        cycle_end,
    output logic        clken,
    output logic        running,
    output logic        stopped,
`ifdef RUNCTL_CYCLE_COUNT_EN
    output logic [15:0] cycle_count,
`endif
    output logic        step_done
);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_STEP    = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    // Button lane indices inside the packed per-button vectors.
    localparam int BTN_RUN  = 0;
    localparam int BTN_STOP = 1;
    localparam int BTN_STEP = 2;
    localparam int NBTN     = 3;

    // A change is accepted on the cycle the counter would reach DEBOUNCE_LEN,
    // so the comparison is against DEBOUNCE_LEN-1 of the stored value.
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_LEN - 1);

    // -----------------------------------------------------------------------
    // Button conditioning: 2-FF synchroniser, debouncer, press-edge detector
    // -----------------------------------------------------------------------
    logic [NBTN-1:0]           btn_raw_n;
    logic [NBTN-1:0]           sync1_q;
    logic [NBTN-1:0]           sync2_q;
    logic [NBTN-1:0]           deb_d;
    logic [NBTN-1:0]           deb_q;
    logic [NBTN-1:0]           deb_last_q;
    logic [NBTN-1:0][DB_W-1:0] cnt_d;
    logic [NBTN-1:0][DB_W-1:0] cnt_q;
    logic [NBTN-1:0]           press_d;
    logic [NBTN-1:0]           press_q;

    assign btn_raw_n = {fp_step_n, fp_stop_n, fp_run_n};

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        for (int i = 0; i < NBTN; i++) begin
            // Any cycle where the synced level agrees with the accepted level
            // restarts the stability window, so bounces never accumulate.
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    deb_d[i] = ~deb_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        // Press is the debounced 1->0 transition; holding gives one pulse and
        // a new press needs the release to debounce first.
        press_d = deb_last_q & ~deb_q;
    end

    always_ff @(posedge rawclk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            deb_q      <= '1;
            deb_last_q <= '1;
            cnt_q      <= '0;
            press_q    <= '0;
        end else begin
            sync1_q    <= btn_raw_n;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_last_q <= deb_q;
            cnt_q      <= cnt_d;
            press_q    <= press_d;
        end
    end

    logic run_ev;
    logic stop_ev;
    logic step_ev;
    logic halt_req;

    assign run_ev   = press_q[BTN_RUN];
    assign stop_ev  = press_q[BTN_STOP];
    assign step_ev  = press_q[BTN_STEP];
    assign halt_req = stop_ev | ~halt_n;

    // -----------------------------------------------------------------------
    // Control FSM: state register
    // -----------------------------------------------------------------------
    state_t state_d;
    state_t state_q;
    logic   clken_d;
    logic   clken_q;
    logic   running_d;
    logic   running_q;
    logic   stopped_d;
    logic   stopped_q;
    logic   step_done_d;
    logic   step_done_q;

    always_ff @(posedge rawclk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_STOPPED;
            clken_q     <= 1'b0;
            running_q   <= 1'b0;
            stopped_q   <= 1'b1;
            step_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clken_q     <= clken_d;
            running_q   <= running_d;
            stopped_q   <= stopped_d;
            step_done_q <= step_done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_STOPPED: begin
                // stop > run > step when events coincide.
                if (stop_ev) begin
                    state_d = ST_STOPPED;
                end else if (run_ev) begin
                    state_d = ST_RUNNING;
                end else if (step_ev) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUNNING: begin
                // A stop/halt arriving on the boundary itself skips DRAIN;
                // otherwise finish the current processor cycle first.
                if (halt_req) begin
                    state_d = cycle_end ? ST_STOPPED : ST_DRAIN;
                end
            end
            ST_STEP: begin
                if (cycle_end) begin
                    state_d = ST_STOPPED;
                end else if (run_ev) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_DRAIN: begin
                if (cycle_end) begin
                    state_d = ST_STOPPED;
                end
            end
            default: state_d = ST_STOPPED;
        endcase
    end

    // -----------------------------------------------------------------------
    // Control FSM: output logic (decoded from next state, then registered so
    // clken changes on the same edge as the state)
    // -----------------------------------------------------------------------
    always_comb begin
        clken_d     = (state_d != ST_STOPPED);
        running_d   = (state_d == ST_RUNNING);
        stopped_d   = (state_d == ST_STOPPED);
        // Only a step that completes (not one converted to RUNNING) reports.
        step_done_d = (state_q == ST_STEP) && cycle_end;
    end

    assign clken     = clken_q;
    assign running   = running_q;
    assign stopped   = stopped_q;
    assign step_done = step_done_q;

`ifdef RUNCTL_CYCLE_COUNT_EN
    // -----------------------------------------------------------------------
    // Completed-cycle counter: counts boundaries of enabled processor cycles
    // -----------------------------------------------------------------------
    logic [15:0] cycle_count_d;
    logic [15:0] cycle_count_q;

    always_comb begin
        cycle_count_d = cycle_count_q;
        if (cycle_end && clken_q) begin
            cycle_count_d = cycle_count_q + 16'd1;
        end
    end

    always_ff @(posedge rawclk or negedge reset) begin
        if (!reset) begin
            cycle_count_q <= 16'd0;
        end else begin
            cycle_count_q <= cycle_count_d;
        end
    end

    assign cycle_count = cycle_count_q;
`endif

endmodule

// File: tb/tb_run_control.sv
// ---------------------------------------------------------------------------
// tb_run_control
//
// Directed bench for run_control with DEBOUNCE_LEN=8. Inputs change 1 ns
// after a rising edge; outputs are checked at that same point, i.e. they show
// what the preceding edge registered. Define RUNCTL_CYCLE_COUNT_EN to also
// exercise the completed-cycle counter.
// ---------------------------------------------------------------------------
module tb_run_control;

    logic        rawclk;
    logic        reset;
    logic        fp_run_n;
    logic        fp_stop_n;
    logic        fp_step_n;
    logic        halt_n;
    logic        cycle_end;
    logic        clken;
    logic        running;
    logic        stopped;
    logic        step_done;
`ifdef RUNCTL_CYCLE_COUNT_EN
    logic [15:0] cycle_count;
`endif

    int n_checks;
    int n_pass;

    run_control #(
        .DB_W         (4),
        .DEBOUNCE_LEN (8)
    ) dut (
        .rawclk      (rawclk),
        .reset       (reset),
        .fp_run_n    (fp_run_n),
        .fp_stop_n   (fp_stop_n),
        .fp_step_n   (fp_step_n),
        .halt_n      (halt_n),
        .cycle_end   (cycle_end),
        .clken       (clken),
        .running     (running),
        .stopped     (stopped),
`ifdef RUNCTL_CYCLE_COUNT_EN
        .cycle_count (cycle_count),
`endif
        .step_done   (step_done)
    );

    initial rawclk = 1'b0;
    always #5 rawclk = ~rawclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge rawclk);
            #1;
        end
    endtask

    // Press is applied just after an edge, so the next edge is N; after k
    // ticks the last edge seen is N+k-1. State changes at N+11 -> 12 ticks.
    task automatic run_press_and_release();
        fp_run_n = 1'b0;
        tick(12);
        fp_run_n = 1'b1;
        tick(12);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b0;
        fp_run_n  = 1'b1;
        fp_stop_n = 1'b1;
        fp_step_n = 1'b1;
        halt_n    = 1'b1;
        cycle_end = 1'b0;

        // Reset state
        tick(3);
        check("rst_clken", clken, 0);
        check("rst_running", running, 0);
        check("rst_stopped", stopped, 1);
        check("rst_step_done", step_done, 0);
        reset = 1'b1;
        tick(2);

        // Clean RUN press: clken rises exactly at edge N+11
        fp_run_n = 1'b0;
        tick(11);
        check("run_before_n11", clken, 0);
        tick(1);
        check("run_at_n11_clken", clken, 1);
        check("run_at_n11_running", running, 1);
        check("run_at_n11_stopped", stopped, 0);
        tick(8);
        fp_run_n = 1'b1;
        tick(15);
        check("run_after_release", clken, 1);
        check("run_after_release_lamp", running, 1);

        // HALT for one cycle -> DRAIN until the cycle boundary
        halt_n = 1'b0;
        tick(1);
        halt_n = 1'b1;
        check("drain_clken", clken, 1);
        check("drain_running", running, 0);
        check("drain_stopped", stopped, 0);
        tick(4);
        check("drain_hold", clken, 1);
        cycle_end = 1'b1;
        tick(1);
        cycle_end = 1'b0;
        check("drain_end_clken", clken, 0);
        check("drain_end_stopped", stopped, 1);

        // Bouncing RUN (3 low / 3 high) never debounces
        for (int i = 0; i < 30; i++) begin
            fp_run_n = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
            tick(1);
        end
        fp_run_n = 1'b1;
        tick(15);
        check("bounce_clken", clken, 0);
        check("bounce_stopped", stopped, 1);

        // Single step: completes on cycle_end, step_done for one cycle
        fp_step_n = 1'b0;
        tick(12);
        fp_step_n = 1'b1;
        check("step_clken", clken, 1);
        check("step_running", running, 0);
        check("step_stopped", stopped, 0);
        tick(9);
        cycle_end = 1'b1;
        tick(1);
        cycle_end = 1'b0;
        check("step_end_clken", clken, 0);
        check("step_end_done", step_done, 1);
        check("step_end_stopped", stopped, 1);
        tick(1);
        check("step_done_one_cycle", step_done, 0);
        tick(12);

        // RUNNING, stop event coincident with cycle_end -> straight to STOPPED
        run_press_and_release();
        check("run2_running", running, 1);
        fp_stop_n = 1'b0;
        tick(11);
        check("stop_pending_running", running, 1);
        cycle_end = 1'b1;
        tick(1);
        cycle_end = 1'b0;
        check("stop_ce_stopped", stopped, 1);
        check("stop_ce_clken", clken, 0);
        check("stop_ce_running", running, 0);
        fp_stop_n = 1'b1;
        tick(12);

        // Simultaneous RUN and STOP in STOPPED: stop wins
        fp_run_n  = 1'b0;
        fp_stop_n = 1'b0;
        tick(14);
        check("runstop_clken", clken, 0);
        check("runstop_stopped", stopped, 1);
        fp_run_n  = 1'b1;
        fp_stop_n = 1'b1;
        tick(12);

        // STEP converted to RUNNING by a run event, no step_done
        fp_step_n = 1'b0;
        tick(12);
        fp_step_n = 1'b1;
        check("step2_clken", clken, 1);
        fp_run_n = 1'b0;
        tick(12);
        check("step2run_running", running, 1);
        check("step2run_done", step_done, 0);
        fp_run_n = 1'b1;
        tick(12);
        check("step2run_hold", running, 1);

        // Asynchronous reset between edges drops clken immediately
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_clken", clken, 0);
        check("async_rst_stopped", stopped, 1);
        check("async_rst_running", running, 0);
        @(posedge rawclk);
        #1;
        reset = 1'b1;
        tick(2);

`ifdef RUNCTL_CYCLE_COUNT_EN
        check("cnt_after_reset", cycle_count, 0);
`endif
        run_press_and_release();
        check("run3_running", running, 1);
        for (int i = 0; i < 3; i++) begin
            cycle_end = 1'b1;
            tick(1);
            cycle_end = 1'b0;
            tick(1);
        end
        check("run3_still_running", running, 1);
`ifdef RUNCTL_CYCLE_COUNT_EN
        check("cnt_three", cycle_count, 3);
        cycle_end = 1'b1;
        tick(65532);
        check("cnt_ffff", cycle_count, 16'hFFFF);
        tick(1);
        cycle_end = 1'b0;
        check("cnt_wrap", cycle_count, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
